// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the future receiver:
// parity modes, the 3-bit FSM state encoding and the baud-divider helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    function automatic int ticks(input longint freq, input longint baud);
        return int'(freq / baud);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO; a push is refused while full,
// even when a pop happens in the same cycle.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (count_q == DEPTH_CNT);
    assign empty_o   = (count_q == {(AW + 1){1'b0}});
    assign count_o   = count_q;
    assign data_o    = mem_q[rd_ptr_q];
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;

    // Occupancy next-state: simultaneous push and pop leaves the count unchanged
    always_comb begin
        count_d = count_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW + 1){1'b0}};
        end else begin
            count_q <= count_d;
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_q <= wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_q <= rd_ptr_q;
            end
        end
    end

    // Storage array; contents are meaningless once the pointers are reset
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: FIFO-buffered valid/ready input, frame
// format set by DATA_BITS / PARITY / STOP_BITS, each bit exactly TICKS clocks.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int          TICKS     = ticks(CLK_FREQ, BAUD);
    localparam logic [31:0] TICK_LAST = 32'(TICKS - 1);
    localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);

    uart_state_e          state_q;
    uart_state_e          state_d;
    logic [31:0]          cnt_q;
    logic [31:0]          cnt_d;
    logic [3:0]           bit_cnt_q;
    logic [3:0]           bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic                 par_q;
    logic                 par_d;
    logic                 tx_q;
    logic                 tx_d;
    logic                 pop_s;
    logic                 boundary_s;
    logic                 last_bit_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [DATA_BITS-1:0] fifo_data_s;

    // Even mode sends the plain XOR of the data bits, odd mode its inverse
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data);
        logic x;
        x = ^data;
        if (PARITY == PARITY_ODD) begin
            return ~x;
        end else begin
            return x;
        end
    endfunction

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid),
        .data_i  (in_data),
        .pop_i   (pop_s),
        .data_o  (fifo_data_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count)
    );

    assign boundary_s = (cnt_q == TICK_LAST);
    // bit_cnt_q counts data bits in DATA and stop periods in STOP
    assign last_bit_s = (state_q == ST_STOP) ? (bit_cnt_q == LAST_STOP)
                                             : (bit_cnt_q == LAST_DATA);
    assign in_ready   = !fifo_full_s;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty_s;
    assign tx         = tx_q;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (boundary_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (boundary_s && last_bit_s) begin
                    state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (boundary_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (boundary_s && last_bit_s) begin
                    state_d = fifo_empty_s ? ST_IDLE : ST_START;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: divider, bit counter, shift register, parity and next tx level
    always_comb begin
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tx_d      = tx_q;
        pop_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d     = 32'd0;
                bit_cnt_d = 4'd0;
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = fifo_data_s;
                    par_d   = parity_bit(fifo_data_s);
                    tx_d    = 1'b0;
                end else begin
                    tx_d    = 1'b1;
                end
            end
            ST_START: begin
                if (boundary_s) begin
                    cnt_d     = 32'd0;
                    bit_cnt_d = 4'd0;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                end else begin
                    cnt_d     = cnt_q + 32'd1;
                end
            end
            ST_DATA: begin
                if (boundary_s) begin
                    cnt_d = 32'd0;
                    if (last_bit_s) begin
                        bit_cnt_d = 4'd0;
                        tx_d      = (PARITY != PARITY_NONE) ? par_q : 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_PARITY: begin
                if (boundary_s) begin
                    cnt_d     = 32'd0;
                    bit_cnt_d = 4'd0;
                    tx_d      = 1'b1;
                end else begin
                    cnt_d     = cnt_q + 32'd1;
                end
            end
            ST_STOP: begin
                if (boundary_s) begin
                    cnt_d = 32'd0;
                    if (last_bit_s) begin
                        bit_cnt_d = 4'd0;
                        // Chain straight into the next start bit when data is waiting
                        if (!fifo_empty_s) begin
                            pop_s   = 1'b1;
                            shift_d = fifo_data_s;
                            par_d   = parity_bit(fifo_data_s);
                            tx_d    = 1'b0;
                        end else begin
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        tx_d      = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                cnt_d     = 32'd0;
                bit_cnt_d = 4'd0;
                tx_d      = 1'b1;
            end
        endcase
    end

    // Datapath registers; tx resets high so the line idles immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= 32'd0;
            bit_cnt_q <= 4'd0;
            shift_q   <= {DATA_BITS{1'b0}};
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench: four transmitter configurations (8N1, 8E1, 8O1, 7N2)
// at TICKS = 10, compared cycle by cycle against an ideal line waveform.
module tb_uart_tx_cfg;

    localparam int TICKS = 10;

    logic            clk;
    logic            rst;
    logic [3:0][7:0] din;
    logic [3:0]      vld;
    logic [3:0]      rdy_w;
    logic [3:0]      tx_w;
    logic [3:0]      busy_w;
    logic [3:0][2:0] cnt_w;

    int   vectors;
    int   miscompares;
    logic exp_q[$];
    logic act_q[$];

    uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .clk(clk), .rst(rst), .in_data(din[0]), .in_valid(vld[0]), .in_ready(rdy_w[0]),
        .tx(tx_w[0]), .busy(busy_w[0]), .fifo_count(cnt_w[0]));
    uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
        .clk(clk), .rst(rst), .in_data(din[1]), .in_valid(vld[1]), .in_ready(rdy_w[1]),
        .tx(tx_w[1]), .busy(busy_w[1]), .fifo_count(cnt_w[1]));
    uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
        .clk(clk), .rst(rst), .in_data(din[2]), .in_valid(vld[2]), .in_ready(rdy_w[2]),
        .tx(tx_w[2]), .busy(busy_w[2]), .fifo_count(cnt_w[2]));
    uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(0),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
        .clk(clk), .rst(rst), .in_data(din[3][6:0]), .in_valid(vld[3]), .in_ready(rdy_w[3]),
        .tx(tx_w[3]), .busy(busy_w[3]), .fifo_count(cnt_w[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int cfg_nb(input int idx);
        return (idx == 3) ? 7 : 8;
    endfunction

    function automatic int cfg_par(input int idx);
        return (idx == 1) ? 2 : ((idx == 2) ? 1 : 0);
    endfunction

    function automatic int cfg_sb(input int idx);
        return (idx == 3) ? 2 : 1;
    endfunction

    // Ideal line level for every clock cycle of one frame, appended to exp_q
    task automatic append_frame(input int idx, input int data);
        int ones;
        ones = 0;
        repeat (TICKS) exp_q.push_back(1'b0);
        for (int b = 0; b < cfg_nb(idx); b++) begin
            ones += (data >> b) & 1;
            repeat (TICKS) exp_q.push_back(((data >> b) & 1) != 0);
        end
        if (cfg_par(idx) == 2) repeat (TICKS) exp_q.push_back((ones % 2) == 1);
        if (cfg_par(idx) == 1) repeat (TICKS) exp_q.push_back((ones % 2) == 0);
        repeat (cfg_sb(idx) * TICKS) exp_q.push_back(1'b1);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (tx_w[i] !== 1'b1 || rdy_w[i] !== 1'b1 || busy_w[i] !== 1'b0 || cnt_w[i] !== 3'd0) begin
                miscompares++;
                $display("FAIL reset[%0d]: tx=%b rdy=%b busy=%b cnt=%0d, want 1 1 0 0",
                         i, tx_w[i], rdy_w[i], busy_w[i], cnt_w[i]);
            end
        end
        rst = 1'b0;
    endtask

    // One isolated frame: accept latency, exact waveform, busy, return to idle
    task automatic test_frame(input int idx, input int data, input string name);
        int len;
        int bad;
        exp_q.delete();
        act_q.delete();
        append_frame(idx, data);
        len = exp_q.size();
        @(negedge clk);
        din[idx] = 8'(data);
        vld[idx] = 1'b1;
        @(negedge clk);
        vld[idx] = 1'b0;
        din[idx] = ~8'(data);
        vectors++;
        if (cnt_w[idx] !== 3'd1 || tx_w[idx] !== 1'b1) begin
            miscompares++;
            $display("FAIL %s accept: cnt=%0d tx=%b, want cnt=1 tx=1", name, cnt_w[idx], tx_w[idx]);
        end
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            act_q.push_back(tx_w[idx]);
            if (c == len / 2) begin
                vectors++;
                if (busy_w[idx] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s busy_mid: got %b want 1", name, busy_w[idx]);
                end
            end
        end
        bad = -1;
        for (int i = 0; i < len; i++) if (bad < 0 && act_q[i] !== exp_q[i]) bad = i;
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL %s wave: cycle %0d tx=%b want %b", name, bad, act_q[bad], exp_q[bad]);
        end
        @(negedge clk);
        vectors++;
        if (tx_w[idx] !== 1'b1 || busy_w[idx] !== 1'b0) begin
            miscompares++;
            $display("FAIL %s end: tx=%b busy=%b, want 1 0", name, tx_w[idx], busy_w[idx]);
        end
    endtask

    task automatic test_8n1();
        test_frame(0, 8'hA5, "8n1_a5");
    endtask

    task automatic test_parity();
        test_frame(1, 8'hA5, "even_a5");
        test_frame(2, 8'hA5, "odd_a5");
        test_frame(1, 8'h07, "even_07");
    endtask

    task automatic test_7n2();
        test_frame(3, 8'h41, "7n2_41");
    endtask

    task automatic test_back_to_back();
        logic [7:0] w [3];
        logic [2:0] cnt_s [3];
        int bad;
        w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33;
        exp_q.delete();
        act_q.delete();
        for (int i = 0; i < 3; i++) append_frame(0, w[i]);
        @(negedge clk);
        din[0] = w[0];
        vld[0] = 1'b1;
        // Edge 0 accepts the first word, tx falls at edge 1, frames run 100 cycles each
        for (int t = 0; t <= 301; t++) begin
            @(negedge clk);
            if (t < 2) din[0] = w[t + 1];
            else vld[0] = 1'b0;
            if (t >= 1 && t <= 300) act_q.push_back(tx_w[0]);
            if (t == 51) cnt_s[0] = cnt_w[0];
            if (t == 151) cnt_s[1] = cnt_w[0];
            if (t == 251) cnt_s[2] = cnt_w[0];
            if (t == 301) begin
                vectors++;
                if (busy_w[0] !== 1'b0 || tx_w[0] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b end: busy=%b tx=%b, want 0 1", busy_w[0], tx_w[0]);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (cnt_s[i] !== 3'(2 - i)) begin
                miscompares++;
                $display("FAIL b2b count[%0d]: got %0d want %0d", i, cnt_s[i], 2 - i);
            end
        end
        bad = -1;
        for (int i = 0; i < 300; i++) if (bad < 0 && act_q[i] !== exp_q[i]) bad = i;
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL b2b wave: cycle %0d tx=%b want %b", bad, act_q[bad], exp_q[bad]);
        end
    endtask

    task automatic test_fifo_full();
        logic [7:0] w [6];
        int acc_edge [6];
        int widx;
        int bad;
        int want;
        logic will;
        exp_q.delete();
        act_q.delete();
        for (int i = 0; i < 6; i++) begin
            w[i] = 8'($urandom_range(0, 255));
            acc_edge[i] = -1;
            append_frame(0, w[i]);
        end
        widx = 0;
        @(negedge clk);
        din[0] = w[0];
        vld[0] = 1'b1;
        will = rdy_w[0];
        for (int t = 0; t <= 601; t++) begin
            @(negedge clk);
            if (will) begin
                acc_edge[widx] = t;
                widx++;
            end
            if (t >= 1 && t <= 600) act_q.push_back(tx_w[0]);
            if (widx < 6) begin
                din[0] = w[widx];
                vld[0] = 1'b1;
            end else begin
                vld[0] = 1'b0;
            end
            will = vld[0] && rdy_w[0];
            if (t == 601) begin
                vectors++;
                if (busy_w[0] !== 1'b0 || tx_w[0] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL full end: busy=%b tx=%b, want 0 1", busy_w[0], tx_w[0]);
                end
            end
        end
        // Five accepts back to back; the sixth waits for the pop that ends frame one
        // (edge 101), then lands on the following edge
        for (int i = 0; i < 6; i++) begin
            want = (i < 5) ? i : 102;
            vectors++;
            if (acc_edge[i] != want) begin
                miscompares++;
                $display("FAIL full accept[%0d]: edge %0d want %0d", i, acc_edge[i], want);
            end
        end
        bad = -1;
        for (int i = 0; i < 600; i++) if (bad < 0 && act_q[i] !== exp_q[i]) bad = i;
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL full wave: cycle %0d tx=%b want %b", bad, act_q[bad], exp_q[bad]);
        end
    endtask

    task automatic test_reset_midframe();
        logic idle_ok;
        @(negedge clk);
        din[0] = 8'h03;
        vld[0] = 1'b1;
        @(negedge clk);
        din[0] = 8'h5A;
        @(negedge clk);
        din[0] = 8'hC3;
        @(negedge clk);
        vld[0] = 1'b0;
        // Now after edge 2; 36 more edges put the line 37 cycles into the frame (data bit 2 = 0)
        repeat (36) @(negedge clk);
        vectors++;
        if (tx_w[0] !== 1'b0 || cnt_w[0] !== 3'd2) begin
            miscompares++;
            $display("FAIL midframe pre: tx=%b cnt=%0d, want 0 2", tx_w[0], cnt_w[0]);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (tx_w[0] !== 1'b1 || cnt_w[0] !== 3'd0 || busy_w[0] !== 1'b0 || rdy_w[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL midframe rst: tx=%b cnt=%0d busy=%b rdy=%b, want 1 0 0 1",
                     tx_w[0], cnt_w[0], busy_w[0], rdy_w[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        idle_ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) idle_ok = 1'b0;
        end
        vectors++;
        if (idle_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL midframe idle: discarded words still sent (ok=%b want 1)", idle_ok);
        end
        test_frame(0, int'($urandom_range(0, 255)), "post_reset");
    endtask

    task automatic test_random();
        int idx;
        int data;
        for (int n = 0; n < 8; n++) begin
            idx  = int'($urandom_range(0, 3));
            data = int'($urandom_range(0, 255));
            if (idx == 3) data = data & 8'h7F;
            repeat ($urandom_range(0, 4)) @(negedge clk);
            test_frame(idx, data, "random");
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        vld         = 4'b0000;
        din         = '0;
        #1 rst = 1'b1;
        test_reset();
        test_8n1();
        test_parity();
        test_7n2();
        test_back_to_back();
        test_fifo_full();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter with a built-in transmit FIFO, configurable frame format (data bits, parity, stop bits) and a valid/ready input handshake. It sits between any byte-producing logic and the board TX pin. It replaces the fixed 8N1 transmitter for all new designs, and each bit period is exactly the configured number of clock cycles.

## Interface
- CLK_FREQ, 100_000_000: clock frequency in Hz.
- BAUD, 115_200: line rate; TICKS = CLK_FREQ / BAUD (integer truncation), must be ≥ 2.
- DATA_BITS, 8: data bits per frame, legal 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: transmit FIFO entries, power of 2, ≥ 2.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_data  in  DATA_BITS  word to transmit, LSB sent first.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  FIFO can accept a word (= !full).
- tx  out  1  serial line, idle high, registered.
- busy  out  1  FSM not in IDLE or FIFO not empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries.

## Operation
- Push: a word is written on any rising edge with in_valid && in_ready. in_data is captured then and need not be held afterwards.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx = 1. If the FIFO is non-empty, pop the head into the shift register, set tx = 0, clear the divider and go to START.
- START → DATA after TICKS cycles; tx = shift[0].
- DATA: shift right every TICKS cycles; after DATA_BITS bits go to PARITY if PARITY ≠ 0, otherwise to STOP with tx = 1.
- PARITY: tx = XOR of the data bits for even, inverted XOR for odd; after TICKS cycles go to STOP with tx = 1.
- STOP: lasts STOP_BITS × TICKS cycles. At the end, if the FIFO is non-empty, pop and go directly to START with tx = 0 (no idle gap). Otherwise go to IDLE.
- Divider: counts 0..TICKS-1. A bit boundary occurs when the count reaches TICKS-1. The divider is 32 bits wide and wraps to 0 at each boundary.
- FIFO full: in_ready = 0 and the push is refused, even if a pop happens in the same cycle.
- FIFO empty with a pop request: cannot occur; the FSM pops only when not empty.
- Simultaneous push and pop when neither full nor empty: both take effect and fifo_count is unchanged.
- in_data bits above DATA_BITS: not applicable, since the width equals DATA_BITS.

## Timing
- Reset values: tx = 1, in_ready = 1, busy = 0, fifo_count = 0, FSM = IDLE, divider = 0, FIFO pointers = 0.
- Reset mid-frame: tx returns high asynchronously, the frame is abandoned and FIFO contents are discarded.
- Latency: a push at edge k into an empty FIFO with the FSM in IDLE causes fifo_count = 1 after k. tx falls at edge k+1.
- Frame length is (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × TICKS cycles, exact.
- in_ready and fifo_count update on the edge after a push or pop. busy is combinational from the registered state and fifo_count.

## Structure
- Package uart_pkg holds:
  - PARITY_NONE / PARITY_ODD / PARITY_EVEN constants.
  - The FSM state encoding (3-bit).
  - A ticks(freq, baud) constant function.
- The package is shared with the future UART receiver.
- Sub-module uart_fifo: synchronous FIFO parametrised by WIDTH and DEPTH, with push/pop/full/empty/count ports and asynchronous rst. The top level contains the FSM, divider, shift register and parity logic.

## Test plan
Use CLK_FREQ = 1_000_000 and BAUD = 100_000 (TICKS = 10) throughout.
- 8N1, push 0xA5 → tx falls 1 cycle after accept. Sampled mid-bit every 10 cycles it reads 0,1,0,1,0,0,1,0,1,1. Frame is 100 cycles, then busy = 0.
- PARITY = 2 with 0xA5 → parity bit 0. PARITY = 1 with 0xA5 → parity bit 1. PARITY = 2 with 0x07 → parity bit 1. Frame is 110 cycles.
- DATA_BITS = 7, STOP_BITS = 2, push 0x41 → bits 1,0,0,0,0,0,1 and 20 high cycles of stop. Total 100 cycles.
- Back-to-back: push 0x11, 0x22, 0x33 on consecutive cycles → three frames with no idle cycles between a stop bit and the next start bit. Total 300 cycles, fifo_count reads 2 then 1 then 0.
- FIFO_DEPTH = 4, push 6 words with in_valid held high → in_ready drops after 5 accepts (1 in the shift register plus 4 in the FIFO). The 6th word is accepted only after the first frame ends, and no word is lost or duplicated.
- Assert rst 37 cycles into a frame → tx = 1 immediately, fifo_count = 0, busy = 0. A word pushed after reset is transmitted correctly.
